// File: rtl/axi4_mon_pkg.sv
// Shared types and constants for the AXI4 master-monitor write collector.
//
// aw_rec_t   : one captured write address plus the cycle it was accepted.
// pend_rec_t : a write whose address and data have completed and that now
//              waits for its B response; age orders entries with equal IDs.
// The record field widths are fixed here; the collector's ID_WIDTH and
// ADDR_WIDTH parameters must not exceed ID_W and ADDR_W.
package axi4_mon_pkg;

    localparam int ID_W      = 4;
    localparam int ADDR_W    = 32;
    localparam int LEN_W     = 8;
    localparam int SIZE_W    = 3;
    localparam int BURST_W   = 2;
    localparam int RESP_W    = 2;
    localparam int BEATS_W   = 9;   // awlen+1 reaches 256
    localparam int TIME_W    = 32;
    localparam int AGE_W     = 16;  // allocation sequence, compared modulo 2^AGE_W
    localparam int OUT_CNT_W = 5;

    localparam logic [RESP_W-1:0] BRESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] BRESP_EXOKAY = 2'b01;
    localparam logic [RESP_W-1:0] BRESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] BRESP_DECERR = 2'b11;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [ADDR_W-1:0]  addr;
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
        logic [TIME_W-1:0]  t_start;
    } aw_rec_t;

    typedef struct packed {
        aw_rec_t             aw;
        logic [BEATS_W-1:0]  beats;
        logic [AGE_W-1:0]    age;
        logic                valid;
    } pend_rec_t;

    // Number of data beats an AXI burst of the given AWLEN carries.
    function automatic logic [BEATS_W-1:0] burst_beats(input logic [LEN_W-1:0] len);
        return {1'b0, len} + BEATS_W'(1);
    endfunction

endpackage

// File: rtl/axi4_mon_sync_fifo.sv
// Generic single-clock FIFO with full/empty flags and occupancy count.
//
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   push_i, data_i      : write request and data (ignored when full unless
//                         a pop happens in the same cycle)
//   pop_i               : read request (ignored when empty)
//   data_o              : head entry, valid while empty_o is low
//   full_o, empty_o     : occupancy flags
//   count_o             : current number of entries
// DEPTH must be a power of two so the pointers wrap naturally.
module axi4_mon_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: storage is deliberately not reset; the pointers and count alone
    // define which entries are meaningful, so clearing the array buys nothing.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

endmodule

// File: rtl/axi4_master_monitor_wr_collector.sv
// Passive AXI4 write-path collector. Pairs each accepted write address with
// its data beats and its B response and emits one record per write,
// including the AW-to-B latency in cycles. Never drives the bus.
//
// Ports:
//   aclk, areset          : clock, synchronous active-high reset
//   aw*/w*/b*             : observed AXI write channels (inputs only)
//   txn_*                 : completed-transaction record, txn_valid strobes
//                           for one cycle, other fields hold between records
//   err_*                 : single-cycle protocol-error pulses
//   outstanding_cnt       : AW FIFO occupancy plus pending-B occupancy
module axi4_master_monitor_wr_collector
    import axi4_mon_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int AW_DEPTH   = 8,
    parameter int PEND_DEPTH = 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  awvalid,
    input  logic                  awready,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  wvalid,
    input  logic                  wready,
    input  logic                  wlast,
    input  logic                  bvalid,
    input  logic                  bready,
    input  logic [ID_WIDTH-1:0]   bid,
    input  logic [1:0]            bresp,
    output logic                  txn_valid,
    output logic [ID_WIDTH-1:0]   txn_id,
    output logic [ADDR_WIDTH-1:0] txn_addr,
    output logic [7:0]            txn_len,
    output logic [2:0]            txn_size,
    output logic [1:0]            txn_burst,
    output logic [1:0]            txn_resp,
    output logic [8:0]            txn_beats,
    output logic [31:0]           txn_latency,
    output logic                  err_wlast,
    output logic                  err_orphan_b,
    output logic                  err_w_no_aw,
    output logic                  err_overflow,
    output logic [4:0]            outstanding_cnt
);

    localparam int FIFO_CNT_W = $clog2(AW_DEPTH) + 1;
    localparam int PEND_IDX_W = $clog2(PEND_DEPTH);
    localparam int PEND_CNT_W = $clog2(PEND_DEPTH) + 1;

    // Handshakes
    logic aw_hs, w_hs, b_hs;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && bready;

    // State
    logic [TIME_W-1:0]    cyc_q;
    logic [BEATS_W-1:0]   beats_q, beats_d;
    logic [AGE_W-1:0]     seq_q, seq_d;
    pend_rec_t            pend_q [PEND_DEPTH];
    pend_rec_t            pend_d [PEND_DEPTH];

    logic                  txn_valid_q;
    logic [ID_WIDTH-1:0]   txn_id_q;
    logic [ADDR_WIDTH-1:0] txn_addr_q;
    logic [7:0]            txn_len_q;
    logic [2:0]            txn_size_q;
    logic [1:0]            txn_burst_q;
    logic [1:0]            txn_resp_q;
    logic [8:0]            txn_beats_q;
    logic [31:0]           txn_latency_q;
    logic                  err_wlast_q, err_orphan_b_q, err_w_no_aw_q, err_overflow_q;
    logic [OUT_CNT_W-1:0]  outstanding_q, outstanding_d;

    // AW FIFO
    aw_rec_t               aw_new;
    aw_rec_t               fifo_head;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FIFO_CNT_W-1:0] fifo_count, fifo_cnt_d;

    always_comb begin
        aw_new         = '0;
        aw_new.id      = ID_W'(awid);
        aw_new.addr    = ADDR_W'(awaddr);
        aw_new.len     = awlen;
        aw_new.size    = awsize;
        aw_new.burst   = awburst;
        aw_new.t_start = cyc_q;
    end

    axi4_mon_sync_fifo #(
        .WIDTH ($bits(aw_rec_t)),
        .DEPTH (AW_DEPTH)
    ) u_aw_fifo (
        .clk_i   (aclk),
        .rst_i   (areset),
        .push_i  (fifo_push),
        .data_i  (aw_new),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Pending table search: first free slot, and the oldest valid entry
    // whose ID matches the B. Age distance from the current sequence number
    // is largest for the oldest entry, which survives sequence wrap.
    logic                  free_found;
    logic [PEND_IDX_W-1:0] free_idx;
    logic                  match_found;
    logic [PEND_IDX_W-1:0] match_idx;
    logic [AGE_W-1:0]      match_dist;
    logic [AGE_W-1:0]      cand_dist;

    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        match_found = 1'b0;
        match_idx   = '0;
        match_dist  = '0;
        cand_dist   = '0;
        for (int i = 0; i < PEND_DEPTH; i++) begin
            if (!pend_q[i].valid && !free_found) begin
                free_found = 1'b1;
                free_idx   = PEND_IDX_W'(i);
            end
            if (pend_q[i].valid && pend_q[i].aw.id == ID_W'(bid)) begin
                cand_dist = seq_q - pend_q[i].age;
                if (!match_found || cand_dist > match_dist) begin
                    match_found = 1'b1;
                    match_idx   = PEND_IDX_W'(i);
                    match_dist  = cand_dist;
                end
            end
        end
    end

    // Write-burst tracking. When the FIFO is empty, a W in the same cycle
    // as an AW belongs to that incoming AW, which never enters the FIFO if
    // its burst also closes in that cycle.
    aw_rec_t               head_rec;
    logic [BEATS_W-1:0]    beats_inc;
    logic                  hit_last, w_on_head, w_close, aw_consumed, aw_drop;
    logic                  pend_alloc, pend_drop, b_hit;
    logic [PEND_CNT_W-1:0] pend_cnt_d;

    // NOTE: every combinational output gets a default at the top of the
    // block, so no path can leave a value unassigned and infer a latch.
    always_comb begin
        head_rec    = fifo_empty ? aw_new : fifo_head;
        beats_inc   = beats_q + BEATS_W'(1);
        hit_last    = (beats_inc == burst_beats(head_rec.len));
        w_on_head   = w_hs && (!fifo_empty || aw_hs);
        w_close     = w_on_head && (wlast || hit_last);
        aw_consumed = w_close && fifo_empty;
        fifo_pop    = w_close && !fifo_empty;
        aw_drop     = aw_hs && fifo_full && !fifo_pop;
        fifo_push   = aw_hs && !aw_consumed && !aw_drop;
        pend_alloc  = w_close && free_found;
        pend_drop   = w_close && !free_found;
        b_hit       = b_hs && match_found;

        beats_d = w_close ? '0 : (w_on_head ? beats_inc : beats_q);
        seq_d   = seq_q + AGE_W'(pend_alloc);

        pend_d = pend_q;
        if (b_hit) begin
            pend_d[match_idx].valid = 1'b0;
        end
        if (pend_alloc) begin
            pend_d[free_idx].aw    = head_rec;
            pend_d[free_idx].beats = beats_inc;
            pend_d[free_idx].age   = seq_q;
            pend_d[free_idx].valid = 1'b1;
        end

        pend_cnt_d = '0;
        for (int i = 0; i < PEND_DEPTH; i++) begin
            pend_cnt_d = pend_cnt_d + PEND_CNT_W'(pend_d[i].valid);
        end
        fifo_cnt_d    = fifo_count + FIFO_CNT_W'(fifo_push) - FIFO_CNT_W'(fifo_pop);
        outstanding_d = OUT_CNT_W'(fifo_cnt_d) + OUT_CNT_W'(pend_cnt_d);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cyc_q          <= '0;
            beats_q        <= '0;
            seq_q          <= '0;
            for (int i = 0; i < PEND_DEPTH; i++) begin
                pend_q[i].valid <= 1'b0;
            end
            txn_valid_q    <= 1'b0;
            txn_id_q       <= '0;
            txn_addr_q     <= '0;
            txn_len_q      <= '0;
            txn_size_q     <= '0;
            txn_burst_q    <= '0;
            txn_resp_q     <= '0;
            txn_beats_q    <= '0;
            txn_latency_q  <= '0;
            err_wlast_q    <= 1'b0;
            err_orphan_b_q <= 1'b0;
            err_w_no_aw_q  <= 1'b0;
            err_overflow_q <= 1'b0;
            outstanding_q  <= '0;
        end else begin
            cyc_q   <= cyc_q + TIME_W'(1);
            beats_q <= beats_d;
            seq_q   <= seq_d;
            pend_q  <= pend_d;

            txn_valid_q <= b_hit;
            if (b_hit) begin
                txn_id_q      <= ID_WIDTH'(pend_q[match_idx].aw.id);
                txn_addr_q    <= ADDR_WIDTH'(pend_q[match_idx].aw.addr);
                txn_len_q     <= pend_q[match_idx].aw.len;
                txn_size_q    <= pend_q[match_idx].aw.size;
                txn_burst_q   <= pend_q[match_idx].aw.burst;
                txn_resp_q    <= bresp;
                txn_beats_q   <= pend_q[match_idx].beats;
                txn_latency_q <= cyc_q - pend_q[match_idx].aw.t_start;
            end

            // Mismatch either way: early WLAST, or the final beat without it.
            err_wlast_q    <= w_on_head && (wlast != hit_last);
            err_orphan_b_q <= b_hs && !match_found;
            err_w_no_aw_q  <= w_hs && fifo_empty && !aw_hs;
            err_overflow_q <= aw_drop || pend_drop;
            outstanding_q  <= outstanding_d;
        end
    end

    assign txn_valid       = txn_valid_q;
    assign txn_id          = txn_id_q;
    assign txn_addr        = txn_addr_q;
    assign txn_len         = txn_len_q;
    assign txn_size        = txn_size_q;
    assign txn_burst       = txn_burst_q;
    assign txn_resp        = txn_resp_q;
    assign txn_beats       = txn_beats_q;
    assign txn_latency     = txn_latency_q;
    assign err_wlast       = err_wlast_q;
    assign err_orphan_b    = err_orphan_b_q;
    assign err_w_no_aw     = err_w_no_aw_q;
    assign err_overflow    = err_overflow_q;
    assign outstanding_cnt = outstanding_q;

endmodule

// File: tb/tb_axi4_master_monitor_wr_collector.sv
// Scoreboard bench for the AXI4 write collector: stimulus pushes the output
// event it expects (record or error pulses) into a queue; a monitor on the
// falling edge pops and compares whenever the DUT presents an event.
module tb_axi4_master_monitor_wr_collector;

    logic        aclk = 1'b0;
    logic        areset;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [3:0]  awid, bid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, bresp;
    logic        txn_valid;
    logic [3:0]  txn_id;
    logic [31:0] txn_addr;
    logic [7:0]  txn_len;
    logic [2:0]  txn_size;
    logic [1:0]  txn_burst, txn_resp;
    logic [8:0]  txn_beats;
    logic [31:0] txn_latency;
    logic        err_wlast, err_orphan_b, err_w_no_aw, err_overflow;
    logic [4:0]  outstanding_cnt;

    always #5 aclk = ~aclk;

    axi4_master_monitor_wr_collector dut (
        .aclk (aclk), .areset (areset),
        .awvalid (awvalid), .awready (awready), .awid (awid), .awaddr (awaddr),
        .awlen (awlen), .awsize (awsize), .awburst (awburst),
        .wvalid (wvalid), .wready (wready), .wlast (wlast),
        .bvalid (bvalid), .bready (bready), .bid (bid), .bresp (bresp),
        .txn_valid (txn_valid), .txn_id (txn_id), .txn_addr (txn_addr),
        .txn_len (txn_len), .txn_size (txn_size), .txn_burst (txn_burst),
        .txn_resp (txn_resp), .txn_beats (txn_beats), .txn_latency (txn_latency),
        .err_wlast (err_wlast), .err_orphan_b (err_orphan_b),
        .err_w_no_aw (err_w_no_aw), .err_overflow (err_overflow),
        .outstanding_cnt (outstanding_cnt)
    );

    // Error vector order: {wlast, orphan_b, w_no_aw, overflow}
    localparam logic [3:0] E_WLAST = 4'b1000;
    localparam logic [3:0] E_ORPH  = 4'b0100;
    localparam logic [3:0] E_WNOAW = 4'b0010;
    localparam logic [3:0] E_OVF   = 4'b0001;

    typedef struct packed {
        logic        txn;
        logic [3:0]  err;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  resp;
        logic [8:0]  beats;
        logic [31:0] lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic mon_en   = 1'b0;
    logic [4:0] mon_ev;
    exp_t mon_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk_txn(input logic [3:0] id, input logic [31:0] addr,
                                    input logic [7:0] len, input logic [2:0] size,
                                    input logic [1:0] burst, input logic [1:0] resp,
                                    input logic [8:0] beats, input logic [31:0] lat);
        exp_t e;
        e = '0;
        e.txn = 1'b1; e.id = id; e.addr = addr; e.len = len; e.size = size;
        e.burst = burst; e.resp = resp; e.beats = beats; e.lat = lat;
        return e;
    endfunction

    function automatic exp_t mk_err(input logic [3:0] err);
        exp_t e;
        e = '0;
        e.err = err;
        return e;
    endfunction

    // Monitor / scoreboard
    always @(negedge aclk) begin
        if (mon_en) begin
            mon_ev = {txn_valid, err_wlast, err_orphan_b, err_w_no_aw, err_overflow};
            if (mon_ev !== 5'b0) begin
                if (exp_q.size() == 0) begin
                    check("spurious_event", 64'(mon_ev), 64'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("event_kind", 64'(mon_ev), 64'({mon_exp.txn, mon_exp.err}));
                    if (mon_exp.txn) begin
                        check("txn_id",      64'(txn_id),      64'(mon_exp.id));
                        check("txn_addr",    64'(txn_addr),    64'(mon_exp.addr));
                        check("txn_len",     64'(txn_len),     64'(mon_exp.len));
                        check("txn_size",    64'(txn_size),    64'(mon_exp.size));
                        check("txn_burst",   64'(txn_burst),   64'(mon_exp.burst));
                        check("txn_resp",    64'(txn_resp),    64'(mon_exp.resp));
                        check("txn_beats",   64'(txn_beats),   64'(mon_exp.beats));
                        check("txn_latency", 64'(txn_latency), 64'(mon_exp.lat));
                    end
                end
            end
        end
    end

    // Stimulus helpers: set_* prepare one cycle, tick applies it and clears.
    task automatic clr();
        awvalid = 0; awready = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wready = 0; wlast = 0;
        bvalid = 0; bready = 0; bid = 0; bresp = 0;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        clr();
    endtask

    task automatic set_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        awvalid = 1; awready = 1; awid = id; awaddr = addr; awlen = len;
        awsize = size; awburst = burst;
    endtask

    task automatic set_w(input logic last);
        wvalid = 1; wready = 1; wlast = last;
    endtask

    task automatic set_b(input logic [3:0] id, input logic [1:0] resp);
        bvalid = 1; bready = 1; bid = id; bresp = resp;
    endtask

    initial begin
        clr();
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_txn_valid",   64'(txn_valid), 64'd0);
        check("rst_outstanding", 64'(outstanding_cnt), 64'd0);
        check("rst_errors", 64'({err_wlast, err_orphan_b, err_w_no_aw, err_overflow}), 64'd0);
        check("rst_latency",     64'(txn_latency), 64'd0);
        areset = 1'b0;
        mon_en = 1'b1;

        // Single write, len=3, B ten cycles after AW
        set_aw(4'd3, 32'h1000, 8'd3, 3'd2, 2'd1); tick();
        check("t1_outstanding_aw", 64'(outstanding_cnt), 64'd1);
        repeat (3) begin set_w(1'b0); tick(); end
        set_w(1'b1); tick();
        repeat (5) tick();
        exp_q.push_back(mk_txn(4'd3, 32'h1000, 8'd3, 3'd2, 2'd1, 2'd0, 9'd4, 32'd10));
        set_b(4'd3, 2'b00); tick();
        check("t1_outstanding_b", 64'(outstanding_cnt), 64'd0);

        // Out-of-order B responses
        set_aw(4'd1, 32'h10, 8'd0, 3'd2, 2'd1); tick();
        set_aw(4'd2, 32'h20, 8'd0, 3'd2, 2'd1); tick();
        check("t2_outstanding_aw", 64'(outstanding_cnt), 64'd2);
        set_w(1'b1); tick();
        set_w(1'b1); tick();
        check("t2_outstanding_pend", 64'(outstanding_cnt), 64'd2);
        exp_q.push_back(mk_txn(4'd2, 32'h20, 8'd0, 3'd2, 2'd1, 2'd2, 9'd1, 32'd3));
        set_b(4'd2, 2'b10); tick();
        exp_q.push_back(mk_txn(4'd1, 32'h10, 8'd0, 3'd2, 2'd1, 2'd0, 9'd1, 32'd5));
        set_b(4'd1, 2'b00); tick();

        // Same-ID ordering: oldest pending entry answers first
        set_aw(4'd5, 32'h100, 8'd0, 3'd1, 2'd0); tick();
        set_aw(4'd5, 32'h200, 8'd0, 3'd1, 2'd0); tick();
        set_w(1'b1); tick();
        set_w(1'b1); tick();
        exp_q.push_back(mk_txn(4'd5, 32'h100, 8'd0, 3'd1, 2'd0, 2'd0, 9'd1, 32'd4));
        set_b(4'd5, 2'b00); tick();
        exp_q.push_back(mk_txn(4'd5, 32'h200, 8'd0, 3'd1, 2'd0, 2'd1, 9'd1, 32'd4));
        set_b(4'd5, 2'b01); tick();

        // Early WLAST on a len=3 burst
        set_aw(4'd6, 32'h300, 8'd3, 3'd2, 2'd1); tick();
        set_w(1'b0); tick();
        exp_q.push_back(mk_err(E_WLAST));
        set_w(1'b1); tick();
        exp_q.push_back(mk_txn(4'd6, 32'h300, 8'd3, 3'd2, 2'd1, 2'd0, 9'd2, 32'd3));
        set_b(4'd6, 2'b00); tick();

        // Missing WLAST on a len=1 burst: closes at beat 2 anyway
        set_aw(4'd7, 32'h400, 8'd1, 3'd2, 2'd1); tick();
        set_w(1'b0); tick();
        exp_q.push_back(mk_err(E_WLAST));
        set_w(1'b0); tick();
        exp_q.push_back(mk_txn(4'd7, 32'h400, 8'd1, 3'd2, 2'd1, 2'd0, 9'd2, 32'd3));
        set_b(4'd7, 2'b00); tick();

        // AW arriving with a closing W goes to the tail, not the head
        set_aw(4'd1, 32'h700, 8'd0, 3'd2, 2'd1); tick();
        set_aw(4'd2, 32'h800, 8'd0, 3'd2, 2'd1); set_w(1'b1); tick();
        set_w(1'b1); tick();
        exp_q.push_back(mk_txn(4'd1, 32'h700, 8'd0, 3'd2, 2'd1, 2'd0, 9'd1, 32'd3));
        set_b(4'd1, 2'b00); tick();
        exp_q.push_back(mk_txn(4'd2, 32'h800, 8'd0, 3'd2, 2'd1, 2'd0, 9'd1, 32'd3));
        set_b(4'd2, 2'b00); tick();

        // AW and its only W together into an empty FIFO
        set_aw(4'd3, 32'h900, 8'd0, 3'd0, 2'd2); set_w(1'b1); tick();
        exp_q.push_back(mk_txn(4'd3, 32'h900, 8'd0, 3'd0, 2'd2, 2'd0, 9'd1, 32'd1));
        set_b(4'd3, 2'b00); tick();

        // AWVALID without AWREADY is not a handshake
        awvalid = 1; awready = 0; awid = 4'd9; tick();
        check("no_hs_outstanding", 64'(outstanding_cnt), 64'd0);

        // Orphan B with nothing pending
        exp_q.push_back(mk_err(E_ORPH));
        set_b(4'd7, 2'b00); tick();

        // Nine AWs into an eight-deep FIFO
        for (int i = 0; i < 8; i++) begin
            set_aw(4'd4, 32'(i * 16), 8'd0, 3'd2, 2'd1); tick();
        end
        exp_q.push_back(mk_err(E_OVF));
        set_aw(4'd4, 32'h90, 8'd0, 3'd2, 2'd1); tick();
        check("ovf_outstanding", 64'(outstanding_cnt), 64'd8);

        areset = 1'b1; tick(); tick(); areset = 1'b0;
        check("ovf_reset_outstanding", 64'(outstanding_cnt), 64'd0);

        // W with empty AW FIFO
        exp_q.push_back(mk_err(E_WNOAW));
        set_w(1'b1); tick();
        check("wnoaw_outstanding", 64'(outstanding_cnt), 64'd0);

        // Reset mid-burst discards everything silently
        set_aw(4'd9, 32'h500, 8'd3, 3'd2, 2'd1); tick();
        set_w(1'b0); tick();
        set_w(1'b0); tick();
        areset = 1'b1; tick();
        check("midrst_outstanding", 64'(outstanding_cnt), 64'd0);
        check("midrst_txn_valid",   64'(txn_valid), 64'd0);
        areset = 1'b0;

        // Clean write after reset
        set_aw(4'd10, 32'h600, 8'd1, 3'd3, 2'd2); tick();
        set_w(1'b0); tick();
        set_w(1'b1); tick();
        repeat (2) tick();
        exp_q.push_back(mk_txn(4'd10, 32'h600, 8'd1, 3'd3, 2'd2, 2'd3, 9'd2, 32'd5));
        set_b(4'd10, 2'b11); tick();
        check("post_rst_outstanding", 64'(outstanding_cnt), 64'd0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        repeat (2) tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
